// File: rtl/busdispatch_pkg.sv
// busdispatch_pkg: shared types and constants for the registered Wishbone
// dispatcher (busdispatch_reg) and its page decoder (busdispatch_decode).
//   state_t          : dispatcher FSM states IDLE / BUSY / DONE
//   ADR_W/DAT_W/PAGE_W : bus address, data and page widths
//   TIMEOUT_DATA     : read data returned when the watchdog aborts a cycle
//   DEFAULT_PAGE_MAP : page byte per mapped target, byte i -> target i
package busdispatch_pkg;

  localparam int unsigned ADR_W  = 16;
  localparam int unsigned DAT_W  = 8;
  localparam int unsigned PAGE_W = 8;

  localparam logic [DAT_W-1:0] TIMEOUT_DATA = 8'hFF;

  localparam logic [39:0] DEFAULT_PAGE_MAP = {8'h87, 8'h83, 8'h82, 8'h81, 8'h80};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/busdispatch_decode.sv
// busdispatch_decode: combinational page-to-target priority decoder.
//   page : address page (adr[15:8])
//   sel  : index of the first target whose PAGE_MAP byte equals page;
//          NUM_SLAVES-1 (default target) when nothing matches.
module busdispatch_decode
  import busdispatch_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 6,
  parameter logic [PAGE_W*(NUM_SLAVES-1)-1:0] PAGE_MAP = DEFAULT_PAGE_MAP
) (
  input  logic [PAGE_W-1:0]             page,
  output logic [$clog2(NUM_SLAVES)-1:0] sel
);

  localparam int unsigned SEL_W = $clog2(NUM_SLAVES);

  // Scan from the highest mapped target down so the lowest index wins
  // when several map bytes hold the same page.
  always_comb begin
    sel = SEL_W'(NUM_SLAVES - 1);
    for (int unsigned i = NUM_SLAVES - 1; i > 0; i--) begin
      if (page == PAGE_MAP[PAGE_W*(i-1) +: PAGE_W]) begin
        sel = SEL_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/busdispatch_reg.sv
// busdispatch_reg: registered Wishbone dispatcher. One requester port fans
// out to NUM_SLAVES targets chosen by address page; target NUM_SLAVES-1 is
// the catch-all default. Requests are latched in IDLE, presented to the
// selected target in BUSY, and acknowledged to the requester in DONE.
// Optional watchdog: define BUSDISPATCH_TIMEOUT_EN to abort cycles that no
// target acks within TIMEOUT_CYCLES, returning TIMEOUT_DATA and logging it.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i        requester cycle, strobe, write enable
//   wb_adr_i, wb_dat_i         requester address and write data
//   wb_dat_o, wb_ack_o         registered read data, one-cycle ack
//   s_wb_stb_o                 one-hot target strobe
//   s_wb_cyc_o, s_wb_we_o      shared target cycle and write enable
//   s_wb_adr_o, s_wb_dat_o     shared latched address and write data
//   s_wb_dat_i, s_wb_ack_i     per-target read data (slice i) and acks
//   err_o, err_cnt_o           sticky timeout flag, saturating timeout count
//   err_clr_i                  clears err_o and err_cnt_o
module busdispatch_reg
  import busdispatch_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 6,
  parameter logic [PAGE_W*(NUM_SLAVES-1)-1:0] PAGE_MAP = DEFAULT_PAGE_MAP,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wb_stb_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_we_i,
  input  logic [ADR_W-1:0]            wb_adr_i,
  input  logic [DAT_W-1:0]            wb_dat_i,
  output logic [DAT_W-1:0]            wb_dat_o,
  output logic                        wb_ack_o,
  output logic [NUM_SLAVES-1:0]       s_wb_stb_o,
  output logic                        s_wb_cyc_o,
  output logic                        s_wb_we_o,
  output logic [ADR_W-1:0]            s_wb_adr_o,
  output logic [DAT_W-1:0]            s_wb_dat_o,
  input  logic [DAT_W*NUM_SLAVES-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_wb_ack_i,
  output logic                        err_o,
  output logic [7:0]                  err_cnt_o,
  input  logic                        err_clr_i
);

  localparam int unsigned SEL_W = $clog2(NUM_SLAVES);

  state_t state_q, state_d;

  logic [ADR_W-1:0]      adr_q;
  logic [DAT_W-1:0]      wdat_q;
  logic                  we_q;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_dec;
  logic [DAT_W-1:0]      rdat_q;
  logic                  req;
  logic                  ack_sel;
  logic [DAT_W-1:0]      dat_sel;
  logic [NUM_SLAVES-1:0] stb_onehot;
  logic                  wd_expire;
  logic                  timeout_evt;

  assign req = wb_cyc_i & wb_stb_i;

  busdispatch_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .PAGE_MAP   (PAGE_MAP)
  ) u_decode (
    .page (wb_adr_i[ADR_W-1 -: PAGE_W]),
    .sel  (sel_dec)
  );

  // Mux the latched target's ack/data and build its one-hot strobe.
  always_comb begin
    ack_sel    = 1'b0;
    dat_sel    = '0;
    stb_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_sel       = s_wb_ack_i[i];
        dat_sel       = s_wb_dat_i[DAT_W*i +: DAT_W];
        stb_onehot[i] = 1'b1;
      end
    end
  end

  // Priority in BUSY: target ack, then requester abort, then watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = BUSY;
      BUSY: begin
        if (ack_sel)        state_d = DONE;
        else if (!wb_cyc_i) state_d = IDLE;
        else if (wd_expire) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign timeout_evt = (state_q == BUSY) & ~ack_sel & wb_cyc_i & wd_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adr_q  <= '0;
      wdat_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      rdat_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        adr_q  <= wb_adr_i;
        wdat_q <= wb_dat_i;
        we_q   <= wb_we_i;
        sel_q  <= sel_dec;
      end
      if (state_q == BUSY && ack_sel) rdat_q <= dat_sel;
      else if (timeout_evt)          rdat_q <= TIMEOUT_DATA;
    end
  end

  assign wb_dat_o   = rdat_q;
  assign wb_ack_o   = (state_q == DONE);
  assign s_wb_cyc_o = (state_q == BUSY);
  assign s_wb_stb_o = (state_q == BUSY) ? stb_onehot : '0;
  assign s_wb_we_o  = we_q;
  assign s_wb_adr_o = adr_q;
  assign s_wb_dat_o = wdat_q;

`ifdef BUSDISPATCH_TIMEOUT_EN
  logic [7:0] wd_cnt_q;
  logic       err_q;
  logic [7:0] err_cnt_q;

  // Counts BUSY cycles without ack; back to 0 outside BUSY so each
  // transfer starts with a fresh budget.
  always_ff @(posedge clk) begin
    if (!rst_n)                       wd_cnt_q <= '0;
    else if (state_q == BUSY && !ack_sel) wd_cnt_q <= wd_cnt_q + 8'd1;
    else                              wd_cnt_q <= '0;
  end

  assign wd_expire = (wd_cnt_q == 8'(TIMEOUT_CYCLES));

  // A new timeout beats a simultaneous clear: the count restarts at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (timeout_evt) begin
      err_q     <= 1'b1;
      err_cnt_q <= err_clr_i ? 8'd1 :
                   (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end else if (err_clr_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_clr;

  assign wd_expire      = 1'b0;
  assign err_o          = 1'b0;
  assign err_cnt_o      = '0;
  assign unused_err_clr = err_clr_i;
`endif

endmodule

// File: tb/tb_busdispatch_reg.sv
// tb_busdispatch_reg: self-checking bench for busdispatch_reg. Targets are
// modelled as responders that ack a programmable number of cycles after
// their strobe rises (or never), with random spurious acks on unselected
// targets. Expected target, latency, data and error state come from a
// transaction-level reference model.
module tb_busdispatch_reg;

  localparam int NS = 6;
  localparam int TO = 4;
`ifdef BUSDISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [15:0]   wb_adr_i;
  logic [7:0]    wb_dat_i;
  logic [7:0]    wb_dat_o;
  logic          wb_ack_o;
  logic [NS-1:0] s_wb_stb_o;
  logic          s_wb_cyc_o, s_wb_we_o;
  logic [15:0]   s_wb_adr_o;
  logic [7:0]    s_wb_dat_o;
  logic [8*NS-1:0] s_wb_dat_i;
  logic [NS-1:0] s_wb_ack_i;
  logic          err_o;
  logic [7:0]    err_cnt_o;
  logic          err_clr_i;

  int tests = 0;
  int fails = 0;

  int            stb_cnt;
  int            ack_delay;
  bit            ack_silent;
  logic [NS-1:0] spur;

  logic [7:0] pages [5];
  bit         m_err;
  int         m_cnt;

  busdispatch_reg #(
    .NUM_SLAVES     (NS),
    .PAGE_MAP       (40'h87_83_82_81_80),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .s_wb_stb_o (s_wb_stb_o),
    .s_wb_cyc_o (s_wb_cyc_o),
    .s_wb_we_o  (s_wb_we_o),
    .s_wb_adr_o (s_wb_adr_o),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_ack_i (s_wb_ack_i),
    .err_o      (err_o),
    .err_cnt_o  (err_cnt_o),
    .err_clr_i  (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles the current strobe has been high; a target acks when this
  // reaches its delay (delay 0 = combinational ack).
  always @(posedge clk) stb_cnt <= (|s_wb_stb_o) ? stb_cnt + 1 : 0;

  always_comb begin
    s_wb_ack_i = spur & ~s_wb_stb_o;
    if (!ack_silent && stb_cnt == ack_delay) s_wb_ack_i = s_wb_ack_i | s_wb_stb_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_target(input logic [7:0] page);
    for (int i = 0; i < 5; i++) if (page == pages[i]) return i;
    return NS - 1;
  endfunction

  task automatic chk_err(input string tag);
    chk({tag, "_err"}, 64'(err_o), 64'(m_err));
    chk({tag, "_errcnt"}, 64'(err_cnt_o), 64'(m_cnt));
  endtask

  // Entered and left on a negedge. clr_pulse drives err_clr_i into the
  // last BUSY cycle of the transfer.
  task automatic xfer(input string tag, input logic [15:0] adr, input logic we,
                      input logic [7:0] wd, input int d, input bit silent,
                      input bit clr_pulse);
    int idx, lat, first;
    bit to, bad;
    logic [7:0] edat, rdat;
    logic [NS-1:0] oh;
    idx  = ref_target(adr[15:8]);
    oh   = NS'(1) << idx;
    to   = TO_EN && (silent || d > TO);
    lat  = to ? TO + 2 : d + 2;
    for (int i = 0; i < NS; i++) s_wb_dat_i[i*8 +: 8] = 8'($urandom());
    edat = to ? 8'hFF : s_wb_dat_i[idx*8 +: 8];
    ack_delay  = d;
    ack_silent = silent;
    spur       = NS'($urandom());
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wd;
    first = 0; bad = 1'b0; rdat = '0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_adr"}, 64'(s_wb_adr_o), 64'(adr));
        chk({tag, "_wdat"}, 64'(s_wb_dat_o), 64'(wd));
        chk({tag, "_we"}, 64'(s_wb_we_o), 64'(we));
        chk({tag, "_cyc"}, 64'(s_wb_cyc_o), 64'(1));
      end
      if (first == 0) begin
        if (wb_ack_o) begin
          first = k;
          rdat  = wb_dat_o;
          if (s_wb_stb_o != '0 || s_wb_cyc_o) bad = 1'b1;
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end else if (s_wb_stb_o != oh) begin
          bad = 1'b1;
        end
      end else if (wb_ack_o || s_wb_stb_o != '0) begin
        bad = 1'b1;
      end
      err_clr_i = clr_pulse && (k == lat - 1);
    end
    err_clr_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk({tag, "_lat"}, 64'(first), 64'(lat));
    chk({tag, "_rdat"}, 64'(rdat), 64'(edat));
    chk({tag, "_stb"}, 64'(bad), 64'(0));
    if (to) begin
      m_err = 1'b1;
      m_cnt = clr_pulse ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
    end else if (clr_pulse) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    chk_err(tag);
  endtask

  // Starts a transfer to a silent target and kills it after two BUSY
  // cycles, by dropping wb_cyc_i or by reset.
  task automatic abort_xfer(input string tag, input bit use_rst, input logic [15:0] adr);
    logic [NS-1:0] oh;
    bit bad;
    oh = NS'(1) << ref_target(adr[15:8]);
    ack_silent = 1'b1;
    spur = NS'($urandom());
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(s_wb_stb_o), 64'(oh));
    if (use_rst) rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk({tag, "_stb0"}, 64'(s_wb_stb_o), 64'(0));
    chk({tag, "_ack0"}, 64'(wb_ack_o), 64'(0));
    if (use_rst) begin
      m_err = 1'b0;
      m_cnt = 0;
      rst_n = 1'b1;
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wb_ack_o || s_wb_stb_o != '0) bad = 1'b1;
    end
    chk({tag, "_quiet"}, 64'(bad), 64'(0));
    ack_silent = 1'b0;
    chk_err(tag);
  endtask

  task automatic pulse_clr(input string tag);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    @(negedge clk);
    m_err = 1'b0;
    m_cnt = 0;
    chk_err(tag);
  endtask

  initial begin
    logic [7:0] rnd_pages [7];
    pages = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h87};
    rnd_pages = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h87, 8'h85, 8'h00};
    m_err = 1'b0; m_cnt = 0;
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; err_clr_i = 1'b0;
    s_wb_dat_i = '0; spur = '0; ack_delay = 0; ack_silent = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({wb_ack_o, s_wb_stb_o, s_wb_cyc_o, s_wb_we_o, s_wb_adr_o,
                           s_wb_dat_o, wb_dat_o, err_o, err_cnt_o}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    xfer("rd_p81_comb", 16'h8100, 1'b0, 8'h11, 0, 1'b0, 1'b0);
    xfer("wr_p87", 16'h8734, 1'b1, 8'hC3, 1, 1'b0, 1'b0);
    xfer("rd_unmapped", 16'h8512, 1'b0, 8'h00, 3, 1'b0, 1'b0);
    xfer("rd_p80_d2", 16'h80FF, 1'b0, 8'h42, 2, 1'b0, 1'b0);

    if (TO_EN) begin
      xfer("to_silent", 16'h8200, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      pulse_clr("clr_after_to");
      xfer("to_again1", 16'h8300, 1'b0, 8'h00, 0, 1'b1, 1'b0);
      xfer("to_again2", 16'h8700, 1'b1, 8'h5A, 0, 1'b1, 1'b0);
      xfer("ack_at_expiry", 16'h8100, 1'b0, 8'h00, TO, 1'b0, 1'b0);
      xfer("to_with_clr", 16'h8500, 1'b0, 8'h00, 0, 1'b1, 1'b1);
      xfer("late_ack_to", 16'h8000, 1'b0, 8'h00, TO + 2, 1'b0, 1'b0);
    end else begin
      xfer("long_wait", 16'h8200, 1'b0, 8'h00, 9, 1'b0, 1'b0);
    end
    pulse_clr("clr_idle");

    abort_xfer("cyc_drop", 1'b0, 16'h8300);
    xfer("after_cyc_drop", 16'h8301, 1'b1, 8'hA5, 1, 1'b0, 1'b0);
    abort_xfer("rst_busy", 1'b1, 16'h8777);
    xfer("after_rst", 16'h8702, 1'b0, 8'h00, 0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] a;
      int d;
      bit sil, clr;
      a   = {rnd_pages[$urandom_range(0, 6)], 8'($urandom())};
      if (a[15:8] == 8'h00) a[15:8] = 8'($urandom());
      d   = $urandom_range(0, 6);
      sil = TO_EN && ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 4) == 0);
      xfer("rand", a, 1'($urandom()), 8'($urandom()), d, sil, clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
